// File: rtl/lsu_dmem_bridge.sv
// rtl/lsu_dmem_bridge.sv - load/store bridge from core memory stage to word-addressed data memory
// Optional feature macro: LSU_MISALIGN_EXC_EN (misaligned half/word requests become errors)
module lsu_dmem_bridge #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic              dmem_read_o,
  output logic              dmem_write_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wr_data_o,
  input  logic [31:0]       dmem_rd_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic        r_uns;
  logic        r_err;
  logic [1:0]  r_size;
  logic [1:0]  r_off;

  logic        w_accept;
  logic        w_misalign;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign req_ready_o = !rst_i && (r_state == S_IDLE);
  assign w_accept    = req_valid_i && req_ready_o;
  assign busy_o      = (r_state != S_IDLE);

`ifdef LSU_MISALIGN_EXC_EN
  assign w_misalign = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                      ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = (req_size_i == 2'b11) || w_misalign;

  // Byte enables and lane-replicated store data for the incoming request
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = req_wdata_i;
    if (!w_err) begin
      case (req_size_i)
        2'b00: begin
          w_be    = 4'b0001 << req_addr_i[1:0];
          w_wdata = {4{req_wdata_i[7:0]}};
        end
        2'b01: begin
          w_be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{req_wdata_i[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = req_wdata_i;
        end
      endcase
    end
  end

  // Lane selection and sign/zero extension of returning read data
  always_comb begin
    w_half = r_off[1] ? dmem_rd_data_i[31:16] : dmem_rd_data_i[15:0];
    case (r_off)
      2'b00:   w_byte = dmem_rd_data_i[7:0];
      2'b01:   w_byte = dmem_rd_data_i[15:8];
      2'b10:   w_byte = dmem_rd_data_i[23:16];
      default: w_byte = dmem_rd_data_i[31:24];
    endcase
    case (r_size)
      2'b00:   w_load = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = dmem_rd_data_i;
    endcase
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = (r_err || r_we) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd0) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Request capture and memory-side address/enables/data, held until next accept
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we           <= 1'b0;
      r_uns          <= 1'b0;
      r_err          <= 1'b0;
      r_size         <= 2'b00;
      r_off          <= 2'b00;
      dmem_addr_o    <= '0;
      dmem_be_o      <= 4'b0000;
      dmem_wr_data_o <= 32'h0;
    end else if (w_accept) begin
      r_we           <= req_we_i;
      r_uns          <= req_unsigned_i;
      r_err          <= w_err;
      r_size         <= req_size_i;
      r_off          <= req_addr_i[1:0];
      dmem_addr_o    <= {req_addr_i[ADDR_W-1:2], 2'b00};
      dmem_be_o      <= w_be;
      dmem_wr_data_o <= w_wdata;
    end
  end

  // Single-cycle strobes during ISSUE; errors never strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dmem_read_o  <= 1'b0;
      dmem_write_o <= 1'b0;
    end else begin
      dmem_read_o  <= w_accept && !w_err && !req_we_i;
      dmem_write_o <= w_accept && !w_err && req_we_i;
    end
  end

  // Read latency down-counter, loaded on the way into WAIT
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= 3'd0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= 3'(MEM_LATENCY - 1);
    end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Response registers: data cleared on accept, filled on final WAIT edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'h0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= (r_state != S_RESP) && (w_next == S_RESP);
      if (w_accept) begin
        rsp_rdata_o <= 32'h0;
        rsp_err_o   <= w_err;
      end else if ((r_state == S_WAIT) && (r_cnt == 3'd0)) begin
        rsp_rdata_o <= w_load;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_bridge.sv
// tb/tb_lsu_dmem_bridge.sv - bench for lsu_dmem_bridge at MEM_LATENCY 1 and 3
module tb_lsu_dmem_bridge;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_maddr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic [1:0]       ready, busy, rsp_valid, rsp_err, dmem_read, dmem_write;
  logic [1:0][31:0] rsp_rdata, dmem_addr, dmem_wd, rd_data;
  logic [1:0][3:0]  dmem_be;

  logic       p1 = 1'b0;
  logic [2:0] p3 = 3'b000;

  int total = 0;
  int bad   = 0;

  lsu_dmem_bridge #(.MEM_LATENCY(1), .ADDR_W(32)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready[0]),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]), .busy_o(busy[0]),
    .dmem_addr_o(dmem_addr[0]), .dmem_read_o(dmem_read[0]), .dmem_write_o(dmem_write[0]),
    .dmem_be_o(dmem_be[0]), .dmem_wr_data_o(dmem_wd[0]), .dmem_rd_data_i(rd_data[0])
  );

  lsu_dmem_bridge #(.MEM_LATENCY(3), .ADDR_W(32)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready[1]),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]), .busy_o(busy[1]),
    .dmem_addr_o(dmem_addr[1]), .dmem_read_o(dmem_read[1]), .dmem_write_o(dmem_write[1]),
    .dmem_be_o(dmem_be[1]), .dmem_wr_data_o(dmem_wd[1]), .dmem_rd_data_i(rd_data[1])
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return 32'h11223344;
      2'd1:    return 32'h80FF1234;
      default: return 32'h00000000;
    endcase
  endfunction

  // Memory model: data is valid only in the cycle the configured latency allows
  always @(posedge clk) begin
    p1 <= dmem_read[0];
    p3 <= {p3[1:0], dmem_read[1]};
  end

  always_comb begin
    rd_data[0] = p1    ? mem_word(dmem_addr[0]) : 32'hDEADBEEF;
    rd_data[1] = p3[2] ? mem_word(dmem_addr[1]) : 32'hDEADBEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_ctl_d%0d", tag, d),
          {26'h0, ready[d], busy[d], dmem_read[d], dmem_write[d], rsp_valid[d], rsp_err[d]}, 32'h0);
      chk($sformatf("%s_be_d%0d", tag, d), {28'h0, dmem_be[d]}, 32'h0);
      chk($sformatf("%s_addr_d%0d", tag, d), dmem_addr[d], 32'h0);
      chk($sformatf("%s_wd_d%0d", tag, d), dmem_wd[d], 32'h0);
      chk($sformatf("%s_rdata_d%0d", tag, d), rsp_rdata[d], 32'h0);
    end
  endtask

  task automatic do_vec(input vec_t v, input string tag);
    int          nrsp[2], lat[2], nwr[2], nrd[2];
    logic [31:0] rdat[2], sbe[2], swd[2], sad[2];
    logic        serr[2];
    for (int d = 0; d < 2; d++) begin
      nrsp[d] = 0; lat[d] = -1; nwr[d] = 0; nrd[d] = 0;
      rdat[d] = 32'hX; sbe[d] = 32'hX; swd[d] = 32'hX; sad[d] = 32'hX; serr[d] = 1'bx;
    end
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    chk({tag, "_ready"}, {30'h0, ready}, 32'h3);
    @(posedge clk);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc == 0) req_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d]) begin
          if (nrsp[d] == 0) begin
            lat[d] = cyc; rdat[d] = rsp_rdata[d]; serr[d] = rsp_err[d];
          end
          nrsp[d]++;
        end
        if (dmem_write[d]) begin
          nwr[d]++; sbe[d] = {28'h0, dmem_be[d]}; swd[d] = dmem_wd[d]; sad[d] = dmem_addr[d];
        end
        if (dmem_read[d]) begin
          nrd[d]++; sbe[d] = {28'h0, dmem_be[d]}; sad[d] = dmem_addr[d];
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      int exp_lat;
      exp_lat = (v.e_err || v.we) ? 1 : ((d == 0) ? 2 : 4);
      chk($sformatf("%s_nrsp_d%0d", tag, d), nrsp[d], 1);
      chk($sformatf("%s_lat_d%0d", tag, d), lat[d], exp_lat);
      chk($sformatf("%s_rdata_d%0d", tag, d), rdat[d], v.e_rdata);
      chk($sformatf("%s_err_d%0d", tag, d), {31'h0, serr[d]}, {31'h0, v.e_err});
      chk($sformatf("%s_nwr_d%0d", tag, d), nwr[d], (!v.e_err && v.we) ? 1 : 0);
      chk($sformatf("%s_nrd_d%0d", tag, d), nrd[d], (!v.e_err && !v.we) ? 1 : 0);
      if (!v.e_err) begin
        chk($sformatf("%s_be_d%0d", tag, d), sbe[d], {28'h0, v.e_be});
        chk($sformatf("%s_maddr_d%0d", tag, d), sad[d], v.e_maddr);
        if (v.we) chk($sformatf("%s_wd_d%0d", tag, d), swd[d], v.e_wd);
      end
    end
  endtask

  vec_t vt[$];
  vec_t v_lw0;
  int   npulse;
  logic [3:0] hold_exp[7];

  initial begin
    vt.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h4, 32'h0000000F, 32'h0, 1'b0, 4'hF, 32'h0000000F, 32'h4});
    vt.push_back(vec_t'{1'b1, 2'b00, 1'b0, 32'h6, 32'h000000A5, 32'h0, 1'b0, 4'h4, 32'hA5A5A5A5, 32'h4});
    vt.push_back(vec_t'{1'b1, 2'b01, 1'b0, 32'h6, 32'h00001234, 32'h0, 1'b0, 4'hC, 32'h12341234, 32'h4});
    vt.push_back(vec_t'{1'b1, 2'b01, 1'b0, 32'h0, 32'hABCD1234, 32'h0, 1'b0, 4'h3, 32'h12341234, 32'h0});
    vt.push_back(vec_t'{1'b1, 2'b00, 1'b0, 32'h1, 32'hFFFFFF5A, 32'h0, 1'b0, 4'h2, 32'h5A5A5A5A, 32'h0});
    vt.push_back(vec_t'{1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'hFFFFFF80, 1'b0, 4'h8, 32'h0, 32'h4});
    vt.push_back(vec_t'{1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 32'h00000080, 1'b0, 4'h8, 32'h0, 32'h4});
    vt.push_back(vec_t'{1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'hFFFF80FF, 1'b0, 4'hC, 32'h0, 32'h4});
    vt.push_back(vec_t'{1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 32'h00001234, 1'b0, 4'h3, 32'h0, 32'h4});
    vt.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h80FF1234, 1'b0, 4'hF, 32'h0, 32'h4});
    vt.push_back(vec_t'{1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 32'h00000033, 1'b0, 4'h2, 32'h0, 32'h0});
    vt.push_back(vec_t'{1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 32'h00001122, 1'b0, 4'hC, 32'h0, 32'h0});
    vt.push_back(vec_t'{1'b0, 2'b00, 1'b0, 32'h6, 32'h0, 32'hFFFFFFFF, 1'b0, 4'h4, 32'h0, 32'h4});
    vt.push_back(vec_t'{1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0});
    vt.push_back(vec_t'{1'b1, 2'b11, 1'b0, 32'h4, 32'h5, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0});
`ifdef LSU_MISALIGN_EXC_EN
    vt.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0});
    vt.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h5, 32'hCAFEF00D, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0});
    vt.push_back(vec_t'{1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0});
`else
    vt.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h11223344, 1'b0, 4'hF, 32'h0, 32'h0});
    vt.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h5, 32'hCAFEF00D, 32'h0, 1'b0, 4'hF, 32'hCAFEF00D, 32'h4});
    vt.push_back(vec_t'{1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 32'h00001234, 1'b0, 4'h3, 32'h0, 32'h4});
`endif
    v_lw0 = vec_t'{1'b0, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h11223344, 1'b0, 4'hF, 32'h0, 32'h0};

    // {ready, busy, read, rsp_valid} of the latency-3 unit with req_valid held high
    hold_exp[0] = 4'b0110; hold_exp[1] = 4'b0100; hold_exp[2] = 4'b0100;
    hold_exp[3] = 4'b0100; hold_exp[4] = 4'b0101; hold_exp[5] = 4'b1000;
    hold_exp[6] = 4'b0110;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {30'h0, ready}, 32'h3);

    for (int i = 0; i < vt.size(); i++) do_vec(vt[i], $sformatf("v%0d", i));

    // Held request: second acceptance only after the first completes
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h4; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      chk($sformatf("hold_c%0d", cyc), {28'h0, ready[1], busy[1], dmem_read[1], rsp_valid[1]},
          {28'h0, hold_exp[cyc]});
    end
    req_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Reset during WAIT drops the request and clears outputs without a clock edge
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h4; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy_before", {31'h0, busy[1]}, 32'h1);
    #1 rst = 1'b1;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    npulse = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) npulse++;
    end
    chk("midrst_no_rsp", npulse, 0);
    do_vec(v_lw0, "post_rst_lw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
